// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage
//   NOP_INSTR     - bubble instruction (addi x0, x0, 0)
//   fetch_state_e - request FSM states
//   fetch_entry_t - one presented instruction slot {pc, instr, valid}
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry output register between fetch and execute
//   clock, reset (async, active low)
//   load/load_entry - capture a returned instruction
//   consume         - downstream took the entry; becomes a NOP bubble
//   flush/flush_pc  - redirect; becomes a NOP bubble tagged with flush_pc
//   entry           - presented {pc, instr, valid}
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         consume,
  input  logic         flush,
  input  logic [31:0]  flush_pc,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) entry <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    else if (flush) entry <= '{pc: flush_pc, instr: NOP_INSTR, valid: 1'b0};
    else if (load) entry <= load_entry;
    else if (consume) entry <= '{pc: entry.pc, instr: NOP_INSTR, valid: 1'b0};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage with one outstanding memory read
//   clock, reset (async, active low), stall, redirect_valid/redirect_pc from execute
//   imem_req/imem_addr/imem_ready request side, imem_rvalid/imem_rdata response side
//   pc_fetch/instruction_fetch/fetch_valid to the fetch->execute register
//   FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and blocks fetch on unaligned redirects
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_fetch,
  output logic [31:0] instruction_fetch,
  output logic        fetch_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);
  fetch_state_e state, state_nxt;
  fetch_entry_t entry;
  logic [31:0] pc, target;
  logic mis, busy, accepted, load;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign target = redirect_pc;
  assign fetch_misaligned = mis;
  always_ff @(posedge clock or negedge reset)
    if (!reset) mis <= 1'b0;
    else if (redirect_valid) mis <= |redirect_pc[1:0];
`else
  assign target = redirect_pc & ~32'd3;
  assign mis = 1'b0;
`endif
  assign busy = state != REQ;
  // Redirect suppresses any new request so the next address issued is the target.
  assign imem_req = reset & ~redirect_valid & ~stall &
                    (state == REQ ? ~mis : (state == WAIT) & imem_rvalid);
  assign imem_addr = pc;
  assign accepted = imem_req & imem_ready;
  // Buffer takes the response when empty or being consumed; otherwise memory holds rvalid.
  assign load = ~redirect_valid & (state == WAIT) & imem_rvalid & (~entry.valid | ~stall);
  always_comb
    state_nxt = redirect_valid ? ((busy && !imem_rvalid) ? DRAIN : REQ) :
                state == DRAIN ? (imem_rvalid ? REQ : DRAIN) :
                accepted ? WAIT :
                (state == WAIT && !load) ? WAIT : REQ;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= redirect_valid ? target : accepted ? pc + 32'd4 : pc;
    end
  // In WAIT the fetch PC is already one word past the outstanding request.
  fetch_buffer u_buf (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .consume    (~stall),
    .flush      (redirect_valid),
    .flush_pc   (target),
    .load_entry ('{pc: pc - 32'd4, instr: imem_rdata, valid: 1'b1}),
    .entry      (entry)
  );
  assign pc_fetch          = entry.pc;
  assign instruction_fetch = entry.instr;
  assign fetch_valid       = entry.valid;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a program-order reference model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clock = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic imem_ready = 1'b1, imem_rvalid = 1'b0, imem_req, fetch_valid;
  logic [31:0] redirect_pc = '0, imem_rdata = '0, imem_addr, pc_fetch, instruction_fetch;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misaligned;
`endif
  int n_chk = 0, n_fail = 0, mem_delay = 0;
  logic chk = 1'b0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_fetch(pc_fetch), .instruction_fetch(instruction_fetch), .fetch_valid(fetch_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h0010_0113 : {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one response per accepted request, rvalid one cycle later, held until taken.
  logic m_acc, m_took, m_rq, m_pend = 1'b0;
  logic [31:0] m_a, m_paddr = '0;
  int m_cnt = 0;
  always begin
    @(negedge clock);
    m_acc  = imem_req & imem_ready;
    m_took = imem_rvalid & (redirect_valid | !(stall & fetch_valid));
    m_rq   = imem_req;
    m_a    = imem_addr;
    @(posedge clock);
    #1;
    if (!reset) begin
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      if (m_took) m_pend = 1'b0;
      if (m_acc) begin
        m_pend  = 1'b1;
        m_paddr = m_a;
        m_cnt   = 0;
      end else if (m_rq) m_cnt++;
    end
    imem_rvalid = m_pend;
    imem_rdata  = m_pend ? mem_word(m_paddr) : 32'h0;
    imem_ready  = m_cnt >= mem_delay;
  end

  // Reference model: valid outputs must walk program order from the last redirect target.
  logic [31:0] exp_pc, p_pc, p_instr, p_addr;
  logic p_stall, p_valid, p_redir, p_hold;
  always @(negedge clock) begin
    s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid;
    s_pc = pc_fetch; s_instr = instruction_fetch;
    if (!chk) begin
      exp_pc = 32'h0; p_stall = 0; p_valid = 0; p_redir = 0; p_hold = 0;
    end else begin
      if (fetch_valid) begin
        check("seq_pc", pc_fetch, exp_pc);
        check("seq_instr", instruction_fetch, mem_word(exp_pc));
      end else check("bubble_nop", instruction_fetch, NOP_INSTR);
      if (p_redir) check("flush_valid", {31'h0, fetch_valid}, 32'h0);
      if (p_stall && p_valid && !p_redir) begin
        check("stall_pc", pc_fetch, p_pc);
        check("stall_instr", instruction_fetch, p_instr);
        check("stall_valid", {31'h0, fetch_valid}, 32'h1);
      end
      if (p_hold && imem_req) check("addr_stable", imem_addr, p_addr);
      if (imem_req && imem_ready)
        check("one_outstanding", {31'h0, imem_rvalid && !(redirect_valid || !(stall && fetch_valid))}, 32'h0);
      if (fetch_valid && !stall) exp_pc = exp_pc + 32'd4;
      if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
      p_stall = stall; p_valid = fetch_valid; p_redir = redirect_valid;
      p_pc = pc_fetch; p_instr = instruction_fetch; p_addr = imem_addr;
      p_hold = imem_req && !imem_ready && !redirect_valid;
    end
  end

  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int d);
    chk = 1'b0; reset = 1'b0; mem_delay = d;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b1; chk = 1'b1;
  endtask

  initial begin
    // Zero-wait memory from reset
    do_reset(0);
    step(0, 0, 0); check("s1_req0", {31'h0, s_req}, 1); check("s1_addr0", s_addr, 0); check("s1_valid0", {31'h0, s_valid}, 0);
    step(0, 0, 0); check("s1_addr1", s_addr, 4); check("s1_valid1", {31'h0, s_valid}, 0);
    step(0, 0, 0); check("s1_valid2", {31'h0, s_valid}, 1); check("s1_pc2", s_pc, 0); check("s1_instr2", s_instr, 32'h0050_0093);
    step(0, 0, 0); check("s1_pc3", s_pc, 4); check("s1_instr3", s_instr, 32'h0010_0113);
    // Stall three cycles with a full buffer and a response waiting
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("s2_req", {31'h0, s_req}, 0); check("s2_pc", s_pc, 8); check("s2_valid", {31'h0, s_valid}, 1);
    end
    step(0, 0, 0); check("s2_pc_rel", s_pc, 8); check("s2_req_rel", {31'h0, s_req}, 1); check("s2_addr_rel", s_addr, 32'h10);
    step(0, 0, 0); check("s2_pc_next", s_pc, 32'hC);
    // Reset mid-operation, then redirect the cycle after 0x8 is accepted
    do_reset(0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 32'h100); check("s3_req_redir", {31'h0, s_req}, 0);
    step(0, 0, 0); check("s3_req", {31'h0, s_req}, 1); check("s3_addr", s_addr, 32'h100); check("s3_flush", {31'h0, s_valid}, 0);
    step(0, 0, 0); check("s3_bubble", {31'h0, s_valid}, 0);
    step(0, 0, 0); check("s3_pc", s_pc, 32'h100); check("s3_instr", s_instr, mem_word(32'h100));
    // Redirect together with stall, unaligned target bits dropped
    step(1, 1, 32'h42);
    step(0, 0, 0); check("s4_valid", {31'h0, s_valid}, 0); check("s4_nop", s_instr, NOP_INSTR); check("s4_addr", s_addr, 32'h40);
    step(0, 0, 0);
    step(0, 0, 0); check("s4_pc", s_pc, 32'h40);
    // PC wraps past the top of the address space
    step(0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0); check("s5_addr0", s_addr, 32'hFFFF_FFF8);
    step(0, 0, 0); check("s5_addr1", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0); check("s5_addr2", s_addr, 32'h0); check("s5_pc0", s_pc, 32'hFFFF_FFF8);
    step(0, 0, 0); check("s5_pc1", s_pc, 32'hFFFF_FFFC);
    step(0, 0, 0); check("s5_pc2", s_pc, 32'h0); check("s5_instr2", s_instr, 32'h0050_0093);
    // Memory with a three-cycle ready delay
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      check("s6_req", {31'h0, s_req}, 1); check("s6_addr", s_addr, 0); check("s6_valid", {31'h0, s_valid}, 0);
    end
    step(0, 0, 0); check("s6_addr4", s_addr, 4); check("s6_valid4", {31'h0, s_valid}, 0);
    step(0, 0, 0); check("s6_valid5", {31'h0, s_valid}, 1); check("s6_pc5", s_pc, 0);
    step(0, 0, 0); check("s6_valid6", {31'h0, s_valid}, 0); check("s6_nop6", s_instr, NOP_INSTR);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0); check("s6_pc9", s_pc, 4);
    // Mixed stalls and a redirect against the model
    do_reset(1);
    for (int i = 0; i < 60; i++) step(i % 7 == 3 || i % 7 == 4, i == 30 || i == 45, i == 30 ? 32'h300 : 32'h500);
`ifdef FETCH_MISALIGN_CHECK_EN
    do_reset(0);
    repeat (4) step(0, 0, 0);
    step(0, 1, 32'h102);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("m_flag", {31'h0, fetch_misaligned}, 1); check("m_req", {31'h0, s_req}, 0);
      check("m_pc", s_pc, 32'h102); check("m_valid", {31'h0, s_valid}, 0);
    end
    step(0, 1, 32'h200);
    step(0, 0, 0); check("m_clear", {31'h0, fetch_misaligned}, 0); check("m_addr", s_addr, 32'h200); check("m_req2", {31'h0, s_req}, 1);
    step(0, 0, 0);
    step(0, 0, 0); check("m_pc2", s_pc, 32'h200); check("m_valid2", {31'h0, s_valid}, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
